// File: rtl/tt_um_unload.sv
// Readback serializer: snapshots the flat weight vector on start and streams it MSB-first, OUT_BITS per beat.
// Latency: first beat valid 1 clock after start; done pulses 1 clock after the last beat is accepted.
// Backpressure: valid/ready; while ui_ready is low the current beat and its index hold; ena=0 freezes everything.
module tt_um_unload #(
    parameter int MAX_IN_LEN  = 16,
    parameter int MAX_OUT_LEN = 8,
    parameter int WIDTH       = 2,
    parameter int OUT_BITS    = 8,
    localparam int TOTAL_BITS = WIDTH * MAX_IN_LEN * MAX_OUT_LEN,
    localparam int BEATS      = TOTAL_BITS / OUT_BITS,
    localparam int BEAT_BITS  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  ui_start,
    input  logic                  ui_abort,
    input  logic                  ui_ready,
    input  logic [TOTAL_BITS-1:0] ui_weights,
    output logic [OUT_BITS-1:0]   uo_data,
    output logic                  uo_valid,
    output logic                  uo_busy,
    output logic [BEAT_BITS-1:0]  uo_beat,
    output logic                  uo_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

    state_t                 r_state;
    logic [TOTAL_BITS-1:0]  r_shadow;
    logic [BEAT_BITS-1:0]   r_beat;

    state_t                 w_state_nxt;
    logic [TOTAL_BITS-1:0]  w_shadow_nxt;
    logic [BEAT_BITS-1:0]   w_beat_nxt;
    logic                   w_valid;
    logic                   w_busy;
    logic                   w_done;

    // State, snapshot and beat counter registers; all updates come from the next-state logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_shadow <= '0;
            r_beat   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_shadow <= w_shadow_nxt;
            r_beat   <= w_beat_nxt;
        end
    end

    // Next-state and output decode; with ena low nothing advances and valid/done are masked.
    always_comb begin
        w_state_nxt  = r_state;
        w_shadow_nxt = r_shadow;
        w_beat_nxt   = r_beat;
        w_valid      = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;

        case (r_state)
            S_SEND: begin
                w_valid = ena;
                w_busy  = 1'b1;
            end
            S_DONE: begin
                w_done = ena;
                w_busy = 1'b1;
            end
            default: begin
                w_valid = 1'b0;
            end
        endcase

        if (ena) begin
            if (ui_abort) begin
                // Abort wins over any transfer this cycle; the snapshot is left as is.
                w_state_nxt = S_IDLE;
                w_beat_nxt  = '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (ui_start) begin
                            w_shadow_nxt = ui_weights;
                            w_beat_nxt   = '0;
                            w_state_nxt  = S_SEND;
                        end
                    end
                    S_SEND: begin
                        if (ui_ready) begin
                            w_shadow_nxt = r_shadow << OUT_BITS;
                            if (r_beat == LAST_BEAT) begin
                                w_beat_nxt  = '0;
                                w_state_nxt = S_DONE;
                            end else begin
                                w_beat_nxt = r_beat + 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        w_state_nxt = S_IDLE;
                    end
                    default: begin
                        w_state_nxt = S_IDLE;
                    end
                endcase
            end
        end
    end

    // The top slice of the snapshot is always the current beat.
    assign uo_data  = r_shadow[TOTAL_BITS-1 -: OUT_BITS];
    assign uo_valid = w_valid;
    assign uo_busy  = w_busy;
    assign uo_beat  = r_beat;
    assign uo_done  = w_done;

endmodule

// File: tb/tb_tt_um_unload.sv
// Bench for the weight readback serializer: random weights and ready patterns against a snapshot model.
module tb_tt_um_unload;

    localparam int TOTAL = 256;
    localparam int BEATS = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ena;
    logic             ui_start;
    logic             ui_abort;
    logic             ui_ready;
    logic [TOTAL-1:0] ui_weights;
    logic [7:0]       uo_data;
    logic             uo_valid;
    logic             uo_busy;
    logic [4:0]       uo_beat;
    logic             uo_done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tt_um_unload dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .ui_start   (ui_start),
        .ui_abort   (ui_abort),
        .ui_ready   (ui_ready),
        .ui_weights (ui_weights),
        .uo_data    (uo_data),
        .uo_valid   (uo_valid),
        .uo_busy    (uo_busy),
        .uo_beat    (uo_beat),
        .uo_done    (uo_done)
    );

    // Beat k of a captured snapshot: byte k counted from the most significant end.
    function automatic logic [7:0] ref_beat(input logic [TOTAL-1:0] snap, input int k);
        logic [TOTAL-1:0] t;
        t = snap >> (TOTAL - 8 - 8 * k);
        return t[7:0];
    endfunction

    function automatic logic [TOTAL-1:0] rand_w();
        logic [TOTAL-1:0] r;
        for (int i = 0; i < TOTAL / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_stream(input logic [TOTAL-1:0] w);
        ui_weights = w;
        ui_start   = 1'b1;
        tick();
        ui_start   = 1'b0;
    endtask

    task automatic go_idle();
        ui_abort = 1'b1;
        tick();
        ui_abort = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [TOTAL-1:0] w;
        rst_n = 1'b0; ena = 1'b1; ui_start = 1'b0; ui_abort = 1'b0; ui_ready = 1'b0;
        ui_weights = rand_w();
        repeat (2) tick();
        #1;
        n_checks++;
        if ({uo_data, uo_valid, uo_busy, uo_beat, uo_done} !== 16'h0) begin
            n_errors++;
            $display("FAIL reset_state: data=%h valid=%b busy=%b beat=%0d done=%b, want all 0", uo_data, uo_valid, uo_busy, uo_beat, uo_done);
        end
        rst_n = 1'b1;
        tick();
        w = rand_w();
        ui_ready = 1'b1;
        start_stream(w);
        tick();
        tick();
        #1;
        n_checks++;
        if (uo_valid !== 1'b1 || uo_beat !== 5'd2 || uo_data !== ref_beat(w, 2)) begin
            n_errors++;
            $display("FAIL reset_pre_stream: valid=%b beat=%0d data=%h, want valid=1 beat=2 data=%h", uo_valid, uo_beat, uo_data, ref_beat(w, 2));
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({uo_data, uo_valid, uo_busy, uo_beat, uo_done} !== 16'h0) begin
            n_errors++;
            $display("FAIL reset_async_mid: data=%h valid=%b busy=%b beat=%0d done=%b, want all 0", uo_data, uo_valid, uo_busy, uo_beat, uo_done);
        end
        #2 rst_n = 1'b1;
        tick();
        w = rand_w();
        start_stream(w);
        #1;
        n_checks++;
        if (uo_valid !== 1'b1 || uo_beat !== 5'd0 || uo_data !== ref_beat(w, 0)) begin
            n_errors++;
            $display("FAIL reset_restart: valid=%b beat=%0d data=%h, want valid=1 beat=0 data=%h", uo_valid, uo_beat, uo_data, ref_beat(w, 0));
        end
        go_idle();
    endtask

    task automatic test_ordered();
        logic [TOTAL-1:0] w;
        for (int i = 0; i < BEATS; i++) w[TOTAL-1-8*i -: 8] = 8'(i);
        ui_ready = 1'b1;
        start_stream(w);
        for (int cyc = 1; cyc <= 34; cyc++) begin
            #1;
            n_checks++;
            if (cyc <= 32) begin
                if (uo_valid !== 1'b1 || uo_data !== 8'(cyc - 1) || uo_beat !== 5'(cyc - 1) || uo_done !== 1'b0 || uo_busy !== 1'b1) begin
                    n_errors++;
                    $display("FAIL ordered_beat cyc=%0d: valid=%b data=%h beat=%0d done=%b busy=%b, want 1/%h/%0d/0/1", cyc, uo_valid, uo_data, uo_beat, uo_done, uo_busy, 8'(cyc - 1), cyc - 1);
                end
            end else if (cyc == 33) begin
                if (uo_done !== 1'b1 || uo_valid !== 1'b0 || uo_busy !== 1'b1) begin
                    n_errors++;
                    $display("FAIL ordered_done cyc=33: done=%b valid=%b busy=%b, want 1/0/1", uo_done, uo_valid, uo_busy);
                end
            end else begin
                if (uo_done !== 1'b0 || uo_valid !== 1'b0 || uo_busy !== 1'b0) begin
                    n_errors++;
                    $display("FAIL ordered_idle cyc=34: done=%b valid=%b busy=%b, want 0/0/0", uo_done, uo_valid, uo_busy);
                end
            end
            tick();
        end
    endtask

    // Streams one snapshot under a ready pattern: 0 = 1,0,0,1 repeating, 1 = random.
    task automatic test_backpressure(input int mode);
        logic [TOTAL-1:0] w;
        int k;
        bit fin;
        w = rand_w();
        k = 0;
        fin = 1'b0;
        start_stream(w);
        for (int c = 0; c < 400 && !fin; c++) begin
            if (mode == 0) ui_ready = ((c % 4) == 0) || ((c % 4) == 3);
            else           ui_ready = 1'($urandom_range(0, 1));
            #1;
            n_checks++;
            if (k < BEATS) begin
                if (uo_valid !== 1'b1 || uo_beat !== 5'(k) || uo_data !== ref_beat(w, k) || uo_done !== 1'b0) begin
                    n_errors++;
                    $display("FAIL bp_beat mode=%0d k=%0d: valid=%b beat=%0d data=%h done=%b, want 1/%0d/%h/0", mode, k, uo_valid, uo_beat, uo_data, uo_done, k, ref_beat(w, k));
                end
                if (ui_ready) k++;
            end else begin
                if (uo_done !== 1'b1 || uo_valid !== 1'b0 || uo_busy !== 1'b1) begin
                    n_errors++;
                    $display("FAIL bp_done mode=%0d: done=%b valid=%b busy=%b, want 1/0/1", mode, uo_done, uo_valid, uo_busy);
                end
                fin = 1'b1;
            end
            tick();
        end
        if (!fin) begin
            n_checks++;
            n_errors++;
            $display("FAIL bp_timeout mode=%0d: reached beat %0d, want done", mode, k);
        end
        #1;
        n_checks++;
        if (uo_busy !== 1'b0 || uo_done !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_after mode=%0d: busy=%b done=%b, want 0/0", mode, uo_busy, uo_done);
        end
        ui_ready = 1'b1;
    endtask

    task automatic test_snapshot();
        logic [TOTAL-1:0] w;
        bit swapped;
        w = rand_w();
        swapped = 1'b0;
        ui_ready = 1'b1;
        start_stream(w);
        for (int k = 0; k < BEATS; k++) begin
            if (k == 5 && !swapped) begin
                ui_weights = '1;
                ui_start   = 1'b1;
                swapped    = 1'b1;
            end else begin
                ui_start = 1'b0;
            end
            #1;
            n_checks++;
            if (uo_valid !== 1'b1 || uo_beat !== 5'(k) || uo_data !== ref_beat(w, k)) begin
                n_errors++;
                $display("FAIL snapshot_beat k=%0d: valid=%b beat=%0d data=%h, want 1/%0d/%h", k, uo_valid, uo_beat, uo_data, k, ref_beat(w, k));
            end
            tick();
        end
        ui_start = 1'b0;
        #1;
        n_checks++;
        if (uo_done !== 1'b1) begin
            n_errors++;
            $display("FAIL snapshot_done: done=%b, want 1", uo_done);
        end
        tick();
    endtask

    task automatic test_abort();
        logic [TOTAL-1:0] w;
        w = rand_w();
        ui_ready = 1'b1;
        start_stream(w);
        repeat (10) tick();
        ui_abort = 1'b1;
        #1;
        n_checks++;
        if (uo_valid !== 1'b1 || uo_beat !== 5'd10 || uo_data !== ref_beat(w, 10)) begin
            n_errors++;
            $display("FAIL abort_at10: valid=%b beat=%0d data=%h, want 1/10/%h", uo_valid, uo_beat, uo_data, ref_beat(w, 10));
        end
        tick();
        ui_abort = 1'b0;
        #1;
        n_checks++;
        if (uo_valid !== 1'b0 || uo_done !== 1'b0 || uo_busy !== 1'b0 || uo_beat !== 5'd0) begin
            n_errors++;
            $display("FAIL abort_next: valid=%b done=%b busy=%b beat=%0d, want 0/0/0/0", uo_valid, uo_done, uo_busy, uo_beat);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (uo_done !== 1'b0 || uo_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL abort_quiet i=%0d: done=%b valid=%b, want 0/0", i, uo_done, uo_valid);
            end
        end
        w = rand_w();
        start_stream(w);
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++;
            if (uo_valid !== 1'b1 || uo_beat !== 5'(k) || uo_data !== ref_beat(w, k)) begin
                n_errors++;
                $display("FAIL abort_resend k=%0d: valid=%b beat=%0d data=%h, want 1/%0d/%h", k, uo_valid, uo_beat, uo_data, k, ref_beat(w, k));
            end
            tick();
        end
        go_idle();
    endtask

    task automatic test_ena();
        logic [TOTAL-1:0] w;
        w = rand_w();
        ui_ready = 1'b1;
        start_stream(w);
        for (int k = 0; k < BEATS; k++) begin
            if (k == 7) begin
                ena = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    #1;
                    n_checks++;
                    if (uo_valid !== 1'b0 || uo_beat !== 5'd7 || uo_done !== 1'b0 || uo_data !== ref_beat(w, 7)) begin
                        n_errors++;
                        $display("FAIL ena_hold i=%0d: valid=%b beat=%0d done=%b data=%h, want 0/7/0/%h", i, uo_valid, uo_beat, uo_done, uo_data, ref_beat(w, 7));
                    end
                    tick();
                end
                ena = 1'b1;
            end
            #1;
            n_checks++;
            if (uo_valid !== 1'b1 || uo_beat !== 5'(k) || uo_data !== ref_beat(w, k)) begin
                n_errors++;
                $display("FAIL ena_beat k=%0d: valid=%b beat=%0d data=%h, want 1/%0d/%h", k, uo_valid, uo_beat, uo_data, k, ref_beat(w, k));
            end
            tick();
        end
        #1;
        n_checks++;
        if (uo_done !== 1'b1) begin
            n_errors++;
            $display("FAIL ena_done: done=%b, want 1", uo_done);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [TOTAL-1:0] w;
        logic [TOTAL-1:0] w2;
        w  = rand_w();
        w2 = rand_w();
        ui_ready = 1'b1;
        start_stream(w);
        repeat (BEATS) tick();
        ui_weights = w2;
        ui_start   = 1'b1;
        #1;
        n_checks++;
        if (uo_done !== 1'b1 || uo_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_done: done=%b valid=%b, want 1/0", uo_done, uo_valid);
        end
        tick();
        #1;
        n_checks++;
        if (uo_valid !== 1'b0 || uo_busy !== 1'b0 || uo_done !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_idle: valid=%b busy=%b done=%b, want 0/0/0", uo_valid, uo_busy, uo_done);
        end
        tick();
        ui_start = 1'b0;
        #1;
        n_checks++;
        if (uo_valid !== 1'b1 || uo_beat !== 5'd0 || uo_data !== ref_beat(w2, 0)) begin
            n_errors++;
            $display("FAIL b2b_restart: valid=%b beat=%0d data=%h, want 1/0/%h", uo_valid, uo_beat, uo_data, ref_beat(w2, 0));
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_ordered();
        test_backpressure(0);
        for (int r = 0; r < 3; r++) test_backpressure(1);
        test_snapshot();
        test_abort();
        test_ena();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
